// File: rtl/fib_checker.sv
// Fibonacci stream checker: compares each accepted term against the expected sequence 0,1,1,2,...
// Optional FIB_CHK_ERRCNT_EN: count mismatches and resynchronise instead of locking.
module fib_checker #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [W-1:0]     exp_data,
    output logic             match,
    output logic             mismatch,
    output logic             error,
    output logic             done,
    output logic [CNT_W-1:0] term_cnt
`ifdef FIB_CHK_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FIRST  = 3'd0,
        S_SECOND = 3'd1,
        S_RUN    = 3'd2,
        S_ERR    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_prev1;
    logic [W-1:0]     r_prev2;
    logic             r_match;
    logic             r_mismatch;
    logic             r_error;
    logic             r_done;
    logic [CNT_W-1:0] r_term_cnt;
`ifdef FIB_CHK_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;
`endif

    logic [W-1:0]     w_exp;
    logic [W-1:0]     w_run_sum;
    logic [W:0]       w_next_sum;
    logic             w_ovf;
    logic             w_ready;
    logic             w_xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_run_sum = r_prev1 + r_prev2;

    // Sum of the pair as it will stand after accepting in_data; overflow means the sequence is complete.
    assign w_next_sum = {1'b0, in_data} + {1'b0, r_prev1};
    assign w_ovf      = w_next_sum > {1'b0, {W{1'b1}}};

    always_comb begin
        w_exp   = '0;
        w_ready = 1'b0;
        case (r_state)
            S_FIRST:  begin w_exp = '0;              w_ready = 1'b1; end
            S_SECOND: begin w_exp = {{(W-1){1'b0}}, 1'b1}; w_ready = 1'b1; end
            S_RUN:    begin w_exp = w_run_sum;       w_ready = 1'b1; end
            default:  begin w_exp = '0;              w_ready = 1'b0; end
        endcase
    end

    assign w_xfer = in_valid && w_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FIRST;
            r_prev1    <= '0;
            r_prev2    <= '0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
            r_term_cnt <= '0;
`ifdef FIB_CHK_ERRCNT_EN
            r_err_cnt  <= '0;
`endif
        end else if (clr) begin
            // A same-cycle transfer is dropped; the mismatch history in err_cnt survives a restart.
            r_state    <= S_FIRST;
            r_prev1    <= '0;
            r_prev2    <= '0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_error    <= 1'b0;
            r_done     <= 1'b0;
            r_term_cnt <= '0;
        end else begin
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            if (w_xfer) begin
                if (in_data == w_exp) begin
                    r_prev2    <= r_prev1;
                    r_prev1    <= in_data;
                    r_term_cnt <= sat_inc(r_term_cnt);
                    r_match    <= 1'b1;
                    if (r_state == S_FIRST) begin
                        r_state <= S_SECOND;
                    end else if (w_ovf) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end else begin
                    r_mismatch <= 1'b1;
                    r_error    <= 1'b1;
`ifdef FIB_CHK_ERRCNT_EN
                    r_state    <= S_FIRST;
                    r_prev1    <= '0;
                    r_prev2    <= '0;
                    r_term_cnt <= '0;
                    r_err_cnt  <= sat_inc(r_err_cnt);
`else
                    r_state    <= S_ERR;
`endif
                end
            end
        end
    end

    assign in_ready = w_ready;
    assign exp_data = w_exp;
    assign match    = r_match;
    assign mismatch = r_mismatch;
    assign error    = r_error;
    assign done     = r_done;
    assign term_cnt = r_term_cnt;
`ifdef FIB_CHK_ERRCNT_EN
    assign err_cnt  = r_err_cnt;
`endif

endmodule

// File: tb/tb_fib_checker.sv
// Directed table-driven bench for fib_checker (W=4, CNT_W=8), with hand-written reset and err_cnt sequences.
module tb_fib_checker;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    typedef struct {
        logic             vld;
        logic [W-1:0]     data;
        logic             clr;
        logic [W-1:0]     e_exp;
        logic             e_rdy;
        logic             e_m;
        logic             e_mm;
        logic             e_err;
        logic             e_done;
        logic [CNT_W-1:0] e_cnt;
        string            name;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_ready;
    logic [W-1:0]     exp_data;
    logic             match;
    logic             mismatch;
    logic             error;
    logic             done;
    logic [CNT_W-1:0] term_cnt;
`ifdef FIB_CHK_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    fib_checker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .exp_data (exp_data),
        .match    (match),
        .mismatch (mismatch),
        .error    (error),
        .done     (done),
        .term_cnt (term_cnt)
`ifdef FIB_CHK_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic v, input logic [W-1:0] d, input logic c,
                       input logic [W-1:0] ee, input logic er, input logic em, input logic emm,
                       input logic eerr, input logic edn, input logic [CNT_W-1:0] ec);
        vec_t r;
        r.vld = v; r.data = d; r.clr = c; r.e_exp = ee; r.e_rdy = er; r.e_m = em;
        r.e_mm = emm; r.e_err = eerr; r.e_done = edn; r.e_cnt = ec; r.name = nm;
        vecs.push_back(r);
    endtask

    task automatic check_outs(input string nm, input vec_t r);
        logic [W+CNT_W+4:0] act, req;
        act = {exp_data, in_ready, match, mismatch, error, done, term_cnt};
        req = {r.e_exp, r.e_rdy, r.e_m, r.e_mm, r.e_err, r.e_done, r.e_cnt};
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got exp=%0d rdy=%b m=%b mm=%b err=%b done=%b cnt=%0d, want exp=%0d rdy=%b m=%b mm=%b err=%b done=%b cnt=%0d",
                     nm, exp_data, in_ready, match, mismatch, error, done, term_cnt,
                     r.e_exp, r.e_rdy, r.e_m, r.e_mm, r.e_err, r.e_done, r.e_cnt);
        end
    endtask

    task automatic step(input vec_t r);
        @(negedge clk);
        in_valid = r.vld;
        in_data  = r.data;
        clr      = r.clr;
        @(posedge clk);
        #1;
        check_outs(r.name, r);
    endtask

    initial begin
        vec_t r;

        // Sequence 1: full reference stream to done.
        add("s1_t0",  1, 0,  0, 1,  1, 1, 0, 0, 0, 1);
        add("s1_t1",  1, 1,  0, 1,  1, 1, 0, 0, 0, 2);
        add("s1_t2",  1, 1,  0, 2,  1, 1, 0, 0, 0, 3);
        add("s1_t3",  1, 2,  0, 3,  1, 1, 0, 0, 0, 4);
        add("s1_t4",  1, 3,  0, 5,  1, 1, 0, 0, 0, 5);
        add("s1_t5",  1, 5,  0, 8,  1, 1, 0, 0, 0, 6);
        add("s1_t6",  1, 8,  0, 13, 1, 1, 0, 0, 0, 7);
        add("s1_t7",  1, 13, 0, 0,  0, 1, 0, 0, 1, 8);
        add("s1_hold",1, 0,  0, 0,  0, 0, 0, 0, 1, 8);
        // Sequence 2: mismatch on the fifth term.
        add("s2_clr", 0, 0,  1, 0,  1, 0, 0, 0, 0, 0);
        add("s2_t0",  1, 0,  0, 1,  1, 1, 0, 0, 0, 1);
        add("s2_t1",  1, 1,  0, 1,  1, 1, 0, 0, 0, 2);
        add("s2_t2",  1, 1,  0, 2,  1, 1, 0, 0, 0, 3);
        add("s2_t3",  1, 2,  0, 3,  1, 1, 0, 0, 0, 4);
`ifdef FIB_CHK_ERRCNT_EN
        add("s2_bad", 1, 4,  0, 0,  1, 0, 1, 1, 0, 0);
        add("s2_ign", 1, 5,  0, 0,  1, 0, 1, 1, 0, 0);
`else
        add("s2_bad", 1, 4,  0, 0,  0, 0, 1, 1, 0, 4);
        add("s2_ign", 1, 5,  0, 0,  0, 0, 0, 1, 0, 4);
`endif
        // Sequence 3: idle gaps between terms.
        add("s3_clr", 0, 0,  1, 0,  1, 0, 0, 0, 0, 0);
        add("s3_t0",  1, 0,  0, 1,  1, 1, 0, 0, 0, 1);
        add("s3_g0a", 0, 9,  0, 1,  1, 0, 0, 0, 0, 1);
        add("s3_g0b", 0, 9,  0, 1,  1, 0, 0, 0, 0, 1);
        add("s3_g0c", 0, 9,  0, 1,  1, 0, 0, 0, 0, 1);
        add("s3_t1",  1, 1,  0, 1,  1, 1, 0, 0, 0, 2);
        add("s3_g1a", 0, 9,  0, 1,  1, 0, 0, 0, 0, 2);
        add("s3_g1b", 0, 9,  0, 1,  1, 0, 0, 0, 0, 2);
        add("s3_g1c", 0, 9,  0, 1,  1, 0, 0, 0, 0, 2);
        add("s3_t2",  1, 1,  0, 2,  1, 1, 0, 0, 0, 3);
        add("s3_g2a", 0, 9,  0, 2,  1, 0, 0, 0, 0, 3);
        // Sequence 4: clr wins over a same-cycle valid term.
        add("s4_clr", 0, 0,  1, 0,  1, 0, 0, 0, 0, 0);
        add("s4_t0",  1, 0,  0, 1,  1, 1, 0, 0, 0, 1);
        add("s4_t1",  1, 1,  0, 1,  1, 1, 0, 0, 0, 2);
        add("s4_t2",  1, 1,  0, 2,  1, 1, 0, 0, 0, 3);
        add("s4_t3",  1, 2,  0, 3,  1, 1, 0, 0, 0, 4);
        add("s4_drop",1, 3,  1, 0,  1, 0, 0, 0, 0, 0);
        add("s4_re0", 1, 0,  0, 1,  1, 1, 0, 0, 0, 1);

        // Reset state, checked before the first clock edge.
        #2;
        r.e_exp = 0; r.e_rdy = 1; r.e_m = 0; r.e_mm = 0; r.e_err = 0; r.e_done = 0; r.e_cnt = 0;
        check_outs("reset", r);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset between edges while in S_RUN, with a match pulse pending.
        r.vld = 0; r.data = 0; r.clr = 1; r.name = "s5_clr";
        r.e_exp = 0; r.e_rdy = 1; r.e_m = 0; r.e_mm = 0; r.e_err = 0; r.e_done = 0; r.e_cnt = 0;
        step(r);
        r.clr = 0; r.vld = 1; r.name = "s5_t0"; r.data = 0; r.e_exp = 1; r.e_m = 1; r.e_cnt = 1;
        step(r);
        r.name = "s5_t1"; r.data = 1; r.e_exp = 1; r.e_cnt = 2;
        step(r);
        r.name = "s5_t2"; r.data = 1; r.e_exp = 2; r.e_cnt = 3;
        step(r);
        #2;
        rst = 1'b0;
        #1;
        r.e_exp = 0; r.e_rdy = 1; r.e_m = 0; r.e_mm = 0; r.e_err = 0; r.e_done = 0; r.e_cnt = 0;
        check_outs("s5_async_rst", r);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outs("s5_release", r);

`ifdef FIB_CHK_ERRCNT_EN
        // Resynchronising mode: 0,1,7,0,1,1.
        r.clr = 0; r.vld = 1; r.e_rdy = 1; r.e_done = 0;
        r.name = "e_t0"; r.data = 0; r.e_exp = 1; r.e_m = 1; r.e_mm = 0; r.e_err = 0; r.e_cnt = 1; step(r);
        r.name = "e_t1"; r.data = 1; r.e_exp = 1; r.e_cnt = 2; step(r);
        r.name = "e_bad"; r.data = 7; r.e_exp = 0; r.e_m = 0; r.e_mm = 1; r.e_err = 1; r.e_cnt = 0; step(r);
        n_checks++;
        if (err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL e_errcnt: got %0d, want 1", err_cnt);
        end
        r.name = "e_r0"; r.data = 0; r.e_exp = 1; r.e_m = 1; r.e_mm = 0; r.e_cnt = 1; step(r);
        r.name = "e_r1"; r.data = 1; r.e_exp = 1; r.e_cnt = 2; step(r);
        r.name = "e_r2"; r.data = 1; r.e_exp = 2; r.e_cnt = 3; step(r);
        n_checks++;
        if (err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL e_errcnt_end: got %0d, want 1", err_cnt);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fib_checker.md
Name: fib_checker

Overview:
- Consumer-side companion to the team's Fibonacci sequence generator.
- Accepts a stream of terms over a valid/ready interface and checks each one against the next expected Fibonacci value, starting from 0, 1.
- Reports per-term match/mismatch pulses, a sticky error flag, a term count, and a done flag when the next term is no longer representable in W bits.
- Sits on the generator's output in self-checking test setups and in on-chip BIST.

Parameters:
- W, 4, width of data terms; the default covers terms up to 13.
- CNT_W, 8, width of the term counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- clr  in  1  synchronous restart of the checker, active-high.
- in_valid  in  1  term present on in_data.
- in_data  in  W  received term.
- in_ready  out  1  checker can accept a term.
- exp_data  out  W  next expected term.
- match  out  1  one-cycle pulse: the last accepted term was correct.
- mismatch  out  1  one-cycle pulse: the last presented term was wrong.
- error  out  1  sticky: at least one mismatch since reset/clr.
- done  out  1  sticky: sequence complete, because the next term would overflow W.
- term_cnt  out  CNT_W  number of correctly accepted terms.

Behaviour:
- Reset (rst=0): state S_FIRST; prev1=0, prev2=0; match, mismatch, error, done and term_cnt all 0.
- States and expected value:
  - S_FIRST: expects 0.
  - S_SECOND: expects 1.
  - S_RUN: expects prev1+prev2.
  - S_ERR: locked after a mismatch.
  - S_DONE: sequence finished.
- exp_data is combinational from state: S_FIRST→0, S_SECOND→1, S_RUN→(prev1+prev2)[W-1:0], S_ERR/S_DONE→0.
- in_ready is 1 in S_FIRST, S_SECOND and S_RUN; 0 in S_ERR and S_DONE.
- Transfer occurs when in_valid && in_ready at a rising clk edge.
- On a transfer with in_data==exp_data:
  - prev2<=prev1, prev1<=in_data.
  - term_cnt increments, saturating at all-ones.
  - match=1 for the following cycle.
  - Next state: S_FIRST→S_SECOND; S_SECOND→S_RUN.
  - From S_RUN, or from S_SECOND: compute the W+1-bit sum of the updated pair (in_data + old prev1). If bit W is set, next state is S_DONE and done=1; otherwise stay in/enter S_RUN.
- On a transfer with in_data!=exp_data:
  - prev1, prev2 and term_cnt unchanged.
  - mismatch=1 for the following cycle; error=1.
  - Next state S_ERR.
- match and mismatch are registered, so their latency is one cycle after the accepting edge. They are never both 1.
- term_cnt and exp_data update on the same edge as the transfer.
- In S_ERR/S_DONE, in_valid is ignored. The block stays there until clr or rst.
- clr=1 at an edge: state S_FIRST; prev, term_cnt, error, done, match and mismatch cleared. clr takes priority over a same-cycle transfer, which is dropped and has no effect.
- rst asserted mid-stream: immediate return to reset values regardless of state or in_valid.
- in_valid low for any number of cycles: all state held, no pulses.
- W=4 reference stream: 0,1,1,2,3,5,8,13. After 13 the sum 8+13=21 overflows, giving done with term_cnt=8.

Optional Feature:
- Macro: FIB_CHK_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt (CNT_W bits, reset 0), which increments on every mismatch and saturates at all-ones.
  - A mismatch does not lock the checker. Next state is S_FIRST with prev and term_cnt cleared, so the checker resynchronises on the next 0.
  - error remains sticky; in_ready stays 1.
- Undefined:
  - No err_cnt port.
  - A mismatch enters S_ERR as above.

Test Plan:
- Reset then feed 0,1,1,2,3,5,8,13 back-to-back → match pulses on each term; term_cnt=8; done=1 and in_ready=0 after 13; error=0.
- Feed 0,1,1,2,4 → four match pulses, then mismatch pulse; error=1; term_cnt=4; in_ready=0. A further in_valid with 5 is ignored.
- Feed 0,1,1 with in_valid gaps of 3 idle cycles between terms → exp_data shows 0,1,1,2 in turn; no pulses during gaps; term_cnt=3.
- Mid-stream after 0,1,1,2, assert clr in the same cycle as in_valid with 3 → transfer dropped; state S_FIRST, exp_data=0, term_cnt=0. Then feeding 0 gives a match.
- Drive rst low asynchronously (between edges) while in S_RUN → all outputs immediately at reset values; exp_data=0; in_ready=1 after release.
- With FIB_CHK_ERRCNT_EN: feed 0,1,7,0,1,1 → mismatch on 7, err_cnt=1, error=1; then three matches, term_cnt=3, in_ready=1 throughout.
